// File: rtl/apb_timer.sv
// Zero-wait APB timer: 32-bit down counter with prescaler, auto-reload and level irq; registers update on the access edge, prdata is combinational.
// No backpressure: every transfer completes in setup + access, irq is registered from next-state so it rises with EXP.
module apb_timer #(
    parameter int CNT_W = 32,
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        irq
);
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_LOAD   = 2'd1;
    localparam logic [1:0] OFF_VALUE  = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    logic             en, auto_rl, ie, expired;
    logic [PSC_W-1:0] presc, psc_cnt;
    logic [CNT_W-1:0] load, value;

    logic             en_nxt, auto_nxt, ie_nxt, exp_nxt;
    logic [PSC_W-1:0] presc_nxt, psc_nxt;
    logic [CNT_W-1:0] load_nxt, value_nxt;

    logic        mapped, wr_any, wr_ctrl, wr_load, wr_status;
    logic        tick, expire;
    logic [31:0] rd_mux;
    logic        unused_addr;

    assign unused_addr = ^{paddr[31:12], paddr[1:0]};

    assign mapped    = (paddr[11:4] == 8'd0);
    assign wr_any    = psel && penable && pwrite && mapped;
    assign wr_ctrl   = wr_any && (paddr[3:2] == OFF_CTRL);
    assign wr_load   = wr_any && (paddr[3:2] == OFF_LOAD);
    assign wr_status = wr_any && (paddr[3:2] == OFF_STATUS);

    assign tick   = en && (psc_cnt == presc);
    // A LOAD write swallows the tick of its own cycle, expiry included.
    assign expire = tick && !wr_load && (value == '0);

    always_comb begin
        en_nxt    = en;
        auto_nxt  = auto_rl;
        ie_nxt    = ie;
        presc_nxt = presc;
        load_nxt  = load;
        value_nxt = value;
        exp_nxt   = expired;
        psc_nxt   = (!en || tick) ? '0 : psc_cnt + PSC_W'(1);

        if (tick && !wr_load) begin
            if (value != '0) begin
                value_nxt = value - CNT_W'(1);
            end else begin
                exp_nxt = 1'b1;
                if (auto_rl) begin
                    value_nxt = load;
                end else begin
                    en_nxt = 1'b0;
                end
            end
        end

        if (wr_status && pwdata[0] && !expire) begin
            exp_nxt = 1'b0;
        end

        if (wr_ctrl) begin
            en_nxt    = pwdata[0];
            auto_nxt  = pwdata[1];
            ie_nxt    = pwdata[2];
            presc_nxt = pwdata[8 +: PSC_W];
            if (!en || !pwdata[0]) begin
                psc_nxt = '0;
            end
        end

        if (wr_load) begin
            load_nxt  = pwdata[CNT_W-1:0];
            value_nxt = pwdata[CNT_W-1:0];
            psc_nxt   = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en      <= 1'b0;
            auto_rl <= 1'b0;
            ie      <= 1'b0;
            presc   <= '0;
            load    <= '0;
            value   <= '0;
            expired <= 1'b0;
            psc_cnt <= '0;
            irq     <= 1'b0;
        end else begin
            en      <= en_nxt;
            auto_rl <= auto_nxt;
            ie      <= ie_nxt;
            presc   <= presc_nxt;
            load    <= load_nxt;
            value   <= value_nxt;
            expired <= exp_nxt;
            psc_cnt <= psc_nxt;
            irq     <= exp_nxt && ie_nxt;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (paddr[3:2])
            OFF_CTRL: begin
                rd_mux[2:0]         = {ie, auto_rl, en};
                rd_mux[8 +: PSC_W]  = presc;
            end
            OFF_LOAD:  rd_mux[CNT_W-1:0] = load;
            OFF_VALUE: rd_mux[CNT_W-1:0] = value;
            default:   rd_mux[0]         = expired;
        endcase
        prdata = (psel && !pwrite && mapped) ? rd_mux : '0;
    end
endmodule

// File: tb/tb_apb_timer.sv
// Bench for apb_timer: directed scenarios plus a randomized bus mix scored against a register-level reference model.
module tb_apb_timer;
    localparam logic [31:0] BASE     = 32'h4001_1000;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_LOAD   = BASE + 32'h4;
    localparam logic [31:0] A_VALUE  = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata;
    logic        irq;

    int vec = 0;
    int fails = 0;

    apb_timer dut (
        .clk     (clk),
        .rstn    (rstn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        auto_rl;
        logic        ie;
        logic        exp_f;
        logic [7:0]  presc;
        logic [7:0]  psc;
        logic [31:0] load;
        logic [31:0] value;
    } model_t;

    model_t m;

    // Register-level behaviour of the timer for one clock edge.
    function automatic model_t model_next(model_t s, logic sel, logic ena, logic wr,
                                          logic [31:0] a, logic [31:0] d);
        model_t n;
        logic do_wr, load_wr, ticks, fired;
        n       = s;
        do_wr   = sel && ena && wr && (a[11:4] == 8'h0);
        load_wr = do_wr && (a[3:2] == 2'd1);
        ticks   = s.en && (s.psc == s.presc);
        fired   = ticks && !load_wr && (s.value == 32'd0);
        n.psc   = (s.en && !ticks) ? s.psc + 8'd1 : 8'd0;
        if (ticks && !load_wr)
            n.value = (s.value != 32'd0) ? s.value - 32'd1 : (s.auto_rl ? s.load : 32'd0);
        if (fired) begin
            n.exp_f = 1'b1;
            if (!s.auto_rl) n.en = 1'b0;
        end
        if (do_wr && a[3:2] == 2'd3 && d[0] && !fired) n.exp_f = 1'b0;
        if (do_wr && a[3:2] == 2'd0) begin
            n.en      = d[0];
            n.auto_rl = d[1];
            n.ie      = d[2];
            n.presc   = d[15:8];
            if (d[0] && !s.en) n.psc = 8'd0;
        end
        if (load_wr) begin
            n.load  = d;
            n.value = d;
            n.psc   = 8'd0;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) m <= '0;
        else       m <= model_next(m, psel, penable, pwrite, paddr, pwdata);
    end

    function automatic logic [31:0] model_read(logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a[11:4] == 8'h0) begin
            case (a[3:2])
                2'd0:    r = {16'h0, m.presc, 5'h0, m.ie, m.auto_rl, m.en};
                2'd1:    r = m.load;
                2'd2:    r = m.value;
                default: r = {31'h0, m.exp_f};
            endcase
        end
        return r;
    endfunction

    task automatic idle(input int n);
        psel = 0; penable = 0; pwrite = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
        @(posedge clk); #1; penable = 1;
        @(posedge clk); #1; psel = 0; penable = 0; pwrite = 0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] got, output logic [31:0] want,
                            output logic gi, output logic wi);
        psel = 1; penable = 0; pwrite = 0; paddr = a;
        @(posedge clk); #1; penable = 1;
        @(negedge clk);
        got  = prdata;
        gi   = irq;
        want = model_read(a);
        wi   = m.exp_f && m.ie;
        @(posedge clk); #1; psel = 0; penable = 0;
    endtask

    task automatic test_reset();
        logic [31:0] got, want; logic gi, wi;
        logic [31:0] addrs [4];
        addrs = '{A_CTRL, A_LOAD, A_VALUE, A_STATUS};
        rstn = 0;
        repeat (3) @(posedge clk);
        #1; rstn = 1;
        foreach (addrs[i]) begin
            apb_read(addrs[i], got, want, gi, wi);
            vec++; if (got !== 32'h0) begin fails++; $display("FAIL reset_read[%0d]: got %h want 0", i, got); end
        end
        vec++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b want 0", irq); end
    endtask

    task automatic test_oneshot();
        logic [31:0] got, want; logic gi, wi;
        apb_write(A_CTRL, 32'h0); apb_write(A_STATUS, 32'h1);
        apb_write(A_LOAD, 32'h3); apb_write(A_CTRL, 32'h5);
        psel = 1; pwrite = 0; penable = 0; paddr = A_VALUE;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++; if (prdata !== 32'(3 - i)) begin fails++; $display("FAIL oneshot_value[%0d]: got %h want %h", i, prdata, 32'(3 - i)); end
            vec++; if (irq !== 1'b0) begin fails++; $display("FAIL oneshot_irq_early[%0d]: got %b want 0", i, irq); end
            @(posedge clk); #1; penable = ~penable;
        end
        vec++; if (irq !== 1'b1) begin fails++; $display("FAIL oneshot_irq: got %b want 1", irq); end
        psel = 0; penable = 0;
        apb_read(A_STATUS, got, want, gi, wi);
        vec++; if (got !== 32'h1) begin fails++; $display("FAIL oneshot_exp: got %h want 1", got); end
        apb_read(A_CTRL, got, want, gi, wi);
        vec++; if (got !== 32'h4) begin fails++; $display("FAIL oneshot_ctrl: got %h want 4", got); end
        idle(3);
        apb_read(A_VALUE, got, want, gi, wi);
        vec++; if (got !== 32'h0) begin fails++; $display("FAIL oneshot_hold: got %h want 0", got); end
    endtask

    task automatic test_auto_prescale();
        logic [31:0] want_v;
        logic        want_e;
        apb_write(A_CTRL, 32'h0); apb_write(A_STATUS, 32'h1);
        apb_write(A_LOAD, 32'h2); apb_write(A_CTRL, 32'h0403);
        psel = 1; pwrite = 0; penable = 0;
        for (int k = 0; k < 35; k++) begin
            want_v = 32'(2 - ((k / 5) % 3));
            want_e = (k >= 15);
            @(negedge clk);
            paddr = A_VALUE; #1;
            vec++; if (prdata !== want_v) begin fails++; $display("FAIL auto_value[%0d]: got %h want %h", k, prdata, want_v); end
            paddr = A_STATUS; #1;
            vec++; if (prdata !== {31'h0, want_e}) begin fails++; $display("FAIL auto_exp[%0d]: got %h want %h", k, prdata, want_e); end
            @(posedge clk); #1; penable = ~penable;
        end
        idle(0);
    endtask

    task automatic test_w1c_race();
        logic [31:0] got, want; logic gi, wi;
        apb_write(A_CTRL, 32'h0); apb_write(A_STATUS, 32'h1);
        apb_write(A_LOAD, 32'h3); apb_write(A_CTRL, 32'h7);
        idle(2);
        apb_write(A_STATUS, 32'h1);
        apb_read(A_STATUS, got, want, gi, wi);
        vec++; if (got !== 32'h1) begin fails++; $display("FAIL w1c_race_exp: got %h want 1", got); end
        vec++; if (gi !== 1'b1) begin fails++; $display("FAIL w1c_race_irq: got %b want 1", gi); end
        apb_write(A_CTRL, 32'h4);
        apb_write(A_STATUS, 32'h0);
        apb_read(A_STATUS, got, want, gi, wi);
        vec++; if (got !== 32'h1) begin fails++; $display("FAIL w1c_zero_write: got %h want 1", got); end
        apb_write(A_CTRL, 32'h0);
        vec++; if (irq !== 1'b0) begin fails++; $display("FAIL ie_mask_irq: got %b want 0", irq); end
        apb_read(A_STATUS, got, want, gi, wi);
        vec++; if (got !== 32'h1) begin fails++; $display("FAIL ie_mask_exp: got %h want 1", got); end
        apb_write(A_CTRL, 32'h4);
        vec++; if (irq !== 1'b1) begin fails++; $display("FAIL ie_unmask_irq: got %b want 1", irq); end
        apb_write(A_STATUS, 32'h1);
        vec++; if (irq !== 1'b0) begin fails++; $display("FAIL w1c_clear_irq: got %b want 0", irq); end
        apb_read(A_STATUS, got, want, gi, wi);
        vec++; if (got !== 32'h0) begin fails++; $display("FAIL w1c_clear_exp: got %h want 0", got); end
    endtask

    task automatic test_bus_decode();
        logic [31:0] got, want; logic gi, wi;
        logic [31:0] ra [6];
        logic [31:0] rv [6];
        apb_write(A_CTRL, 32'h0); apb_write(A_STATUS, 32'h1); apb_write(A_LOAD, 32'h55);
        apb_write(A_VALUE, 32'hDEAD_BEEF);
        apb_write(BASE + 32'h10, 32'hDEAD_BEEF);
        apb_write(BASE + 32'h100, 32'hDEAD_BEEF);
        ra = '{A_LOAD, A_VALUE, A_CTRL, A_STATUS, BASE + 32'h10, BASE + 32'h100};
        rv = '{32'h55, 32'h55, 32'h0, 32'h0, 32'h0, 32'h0};
        foreach (ra[i]) begin
            apb_read(ra[i], got, want, gi, wi);
            vec++; if (got !== rv[i]) begin fails++; $display("FAIL decode_read[%0d]: got %h want %h", i, got, rv[i]); end
        end
        psel = 1; penable = 0; pwrite = 1; paddr = A_LOAD; pwdata = 32'h77;
        repeat (3) begin @(posedge clk); #1; end
        vec++; if (prdata !== 32'h0) begin fails++; $display("FAIL prdata_on_write: got %h want 0", prdata); end
        psel = 0; pwrite = 0; #1;
        vec++; if (prdata !== 32'h0) begin fails++; $display("FAIL prdata_unselected: got %h want 0", prdata); end
        apb_read(A_LOAD, got, want, gi, wi);
        vec++; if (got !== 32'h55) begin fails++; $display("FAIL setup_only_write: got %h want 55", got); end
    endtask

    task automatic test_reload_override();
        logic [31:0] got, want; logic gi, wi;
        apb_write(A_CTRL, 32'h0); apb_write(A_STATUS, 32'h1);
        apb_write(A_LOAD, 32'h2); apb_write(A_CTRL, 32'h0101);
        idle(2);
        apb_write(A_LOAD, 32'h100);
        apb_read(A_VALUE, got, want, gi, wi);
        vec++; if (got !== 32'h100) begin fails++; $display("FAIL reload_value: got %h want 100", got); end
        apb_read(A_STATUS, got, want, gi, wi);
        vec++; if (got !== 32'h0) begin fails++; $display("FAIL reload_exp: got %h want 0", got); end
        apb_read(A_VALUE, got, want, gi, wi);
        vec++; if (got !== 32'hFE) begin fails++; $display("FAIL reload_cadence: got %h want fe", got); end
    endtask

    task automatic test_random();
        logic [31:0] got, want, a, d; logic gi, wi;
        int op;
        for (int n = 0; n < 400; n++) begin
            op = $urandom_range(0, 9);
            a  = BASE | (32'($urandom_range(0, 5)) << 2);
            if ($urandom_range(0, 15) == 0) a = a | 32'h100;
            case (a[3:2])
                2'd0:    d = ($urandom & 32'hFFFF_03FF) | 32'($urandom_range(0, 1));
                2'd1:    d = 32'($urandom_range(0, 6));
                default: d = $urandom;
            endcase
            if (op < 4) begin
                apb_write(a, d);
            end else if (op < 8) begin
                apb_read(a, got, want, gi, wi);
                vec++; if (got !== want) begin fails++; $display("FAIL rand_read[%0d] @%h: got %h want %h", n, a, got, want); end
                vec++; if (gi !== wi) begin fails++; $display("FAIL rand_irq[%0d]: got %b want %b", n, gi, wi); end
            end else if (op == 8) begin
                psel = 1; penable = 0; pwrite = 1; paddr = a; pwdata = d;
                @(posedge clk); #1; psel = 0; pwrite = 0;
            end else begin
                idle($urandom_range(1, 8));
            end
        end
        idle(1);
    endtask

    task automatic test_reset_midcount();
        logic [31:0] got, want; logic gi, wi;
        logic [31:0] addrs [4];
        addrs = '{A_CTRL, A_LOAD, A_VALUE, A_STATUS};
        apb_write(A_CTRL, 32'h0); apb_write(A_STATUS, 32'h1);
        apb_write(A_LOAD, 32'h1); apb_write(A_CTRL, 32'h7);
        idle(3);
        vec++; if (irq !== 1'b1) begin fails++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
        psel = 1; penable = 0; pwrite = 0; paddr = A_CTRL; #1;
        vec++; if (prdata !== 32'h7) begin fails++; $display("FAIL pre_reset_ctrl: got %h want 7", prdata); end
        #1; rstn = 0; #1;
        vec++; if (prdata !== 32'h0) begin fails++; $display("FAIL async_reset_prdata: got %h want 0", prdata); end
        vec++; if (irq !== 1'b0) begin fails++; $display("FAIL async_reset_irq: got %b want 0", irq); end
        @(posedge clk); #1; rstn = 1; psel = 0;
        foreach (addrs[i]) begin
            apb_read(addrs[i], got, want, gi, wi);
            vec++; if (got !== 32'h0) begin fails++; $display("FAIL post_reset_read[%0d]: got %h want 0", i, got); end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_auto_prescale();
        test_w1c_race();
        test_bus_decode();
        test_reload_override();
        test_random();
        test_reset_midcount();
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end
endmodule
